// File: rtl/sccb_cfg_pkg.sv
// Shared definitions for the camera register-table sequencer: opcodes, FSM states, ROM entry layout.
// A ROM word is {op[1:0], dev_id[7:0], reg_addr[15:0], val[7:0]}, MSB first.
package sccb_cfg_pkg;

    typedef enum logic [1:0] {
        OP_WRITE  = 2'd0,
        OP_VERIFY = 2'd1,
        OP_DELAY  = 2'd2,
        OP_END    = 2'd3
    } op_e;

    typedef enum logic [3:0] {
        ST_IDLE   = 4'd0,
        ST_FETCH  = 4'd1,
        ST_DECODE = 4'd2,
        ST_ISSUE  = 4'd3,
        ST_WAIT   = 4'd4,
        ST_CHECK  = 4'd5,
        ST_GAP    = 4'd6,
        ST_DELAY  = 4'd7,
        ST_POST   = 4'd8,
        ST_DONE   = 4'd9,
        ST_ERR    = 4'd10
    } state_e;

    localparam int ENTRY_W  = 34;
    localparam int OP_LSB   = 32;
    localparam int DEV_LSB  = 24;
    localparam int ADDR_LSB = 8;
    localparam int VAL_LSB  = 0;

    typedef struct packed {
        op_e         op;
        logic [7:0]  dev;
        logic [15:0] addr;
        logic [7:0]  val;
    } entry_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/sccb_cfg_seq.sv
// Walks the sensor-init ROM and drives one SCCB transaction engine, with NACK/readback retry.
// Latency: ROM read 1 cycle, 4 cycles from one txn_done to the next entry's txn_start.
// Backpressure: holds in WAIT until the engine's txn_done; never issues a second start meanwhile.
module sccb_cfg_seq
    import sccb_cfg_pkg::*;
#(
    parameter int NUM_ENTRIES = 122,
    parameter int IDX_W       = $clog2(NUM_ENTRIES + 1),
    parameter int REG_AW      = 16,
    parameter int MAX_RETRY   = 3,
    parameter int RETRY_GAP   = 2000,
    parameter int DLY_UNIT    = 1000,
    parameter int POST_DELAY  = 10000,
    parameter bit AUTO_START  = 1'b1
) (
    input  logic             sclk,
    input  logic             s_rst_n,
    input  logic             cfg_restart,
    output logic [IDX_W-1:0] rom_addr,
    input  logic [33:0]      rom_data,
    output logic             txn_start,
    output logic             txn_rd,
    output logic [7:0]       txn_dev,
    output logic [15:0]      txn_addr,
    output logic [7:0]       txn_wdata,
    input  logic             txn_done,
    input  logic             txn_nack,
    input  logic [7:0]       txn_rdata,
    output logic             cfg_busy,
    output logic             cfg_done,
    output logic             cfg_err,
    output logic [IDX_W-1:0] err_index
);

    localparam int CNT_W = $clog2(max3(255 * DLY_UNIT, POST_DELAY, RETRY_GAP) + 1);
    localparam int RTY_W = (MAX_RETRY < 1) ? 1 : $clog2(MAX_RETRY + 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [IDX_W-1:0]   err_idx_q, err_idx_d;
    logic [RTY_W-1:0]   rty_q, rty_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    entry_t             ent_q, ent_d;
    entry_t             rom_ent;
    logic               rd_q, rd_d;
    logic               nack_q, nack_d;
    logic [7:0]         rdata_q, rdata_d;
    logic               retry;
    logic               next_entry;

    always_comb begin
        rom_ent = entry_t'(rom_data);
        if (REG_AW == 8) rom_ent.addr[15:8] = 8'h00;
    end

    always_ff @(posedge sclk or negedge s_rst_n) begin
        if (!s_rst_n) begin
            state_q   <= ST_IDLE;
            idx_q     <= '0;
            err_idx_q <= '0;
            rty_q     <= '0;
            cnt_q     <= '0;
            ent_q     <= '0;
            rd_q      <= 1'b0;
            nack_q    <= 1'b0;
            rdata_q   <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            err_idx_q <= err_idx_d;
            rty_q     <= rty_d;
            cnt_q     <= cnt_d;
            ent_q     <= ent_d;
            rd_q      <= rd_d;
            nack_q    <= nack_d;
            rdata_q   <= rdata_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        err_idx_d  = err_idx_q;
        rty_d      = rty_q;
        cnt_d      = cnt_q;
        ent_d      = ent_q;
        rd_d       = rd_q;
        nack_d     = nack_q;
        rdata_d    = rdata_q;
        retry      = 1'b0;
        next_entry = 1'b0;
        case (state_q)
            ST_IDLE:   if (AUTO_START || cfg_restart) state_d = ST_FETCH;
            ST_FETCH:  state_d = ST_DECODE;
            ST_DECODE: begin
                ent_d = rom_ent;
                rd_d  = 1'b0;
                case (rom_ent.op)
                    OP_WRITE, OP_VERIFY: state_d = ST_ISSUE;
                    OP_DELAY: begin
                        if (rom_ent.val == 8'd0) begin
                            next_entry = 1'b1;
                        end else begin
                            cnt_d   = CNT_W'(rom_ent.val) * CNT_W'(DLY_UNIT);
                            state_d = ST_DELAY;
                        end
                    end
                    default: begin
                        cnt_d   = CNT_W'(POST_DELAY);
                        state_d = ST_POST;
                    end
                endcase
            end
            ST_ISSUE:  state_d = ST_WAIT;
            ST_WAIT: begin
                if (txn_done) begin
                    nack_d  = txn_nack;
                    rdata_d = txn_rdata;
                    state_d = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (nack_q || (rd_q && rdata_q != ent_q.val)) begin
                    retry = 1'b1;
                end else if (ent_q.op == OP_VERIFY && !rd_q) begin
                    rd_d    = 1'b1;
                    state_d = ST_ISSUE;
                end else begin
                    next_entry = 1'b1;
                end
            end
            // Timed states run for max(load value, 1) cycles; the down-counter never wraps.
            ST_GAP:   if (cnt_q <= CNT_W'(1)) state_d = ST_ISSUE; else cnt_d = cnt_q - CNT_W'(1);
            ST_DELAY: if (cnt_q <= CNT_W'(1)) next_entry = 1'b1;  else cnt_d = cnt_q - CNT_W'(1);
            ST_POST:  if (cnt_q <= CNT_W'(1)) state_d = ST_DONE;  else cnt_d = cnt_q - CNT_W'(1);
            ST_DONE, ST_ERR: begin
                if (cfg_restart) begin
                    idx_d     = '0;
                    rty_d     = '0;
                    err_idx_d = '0;
                    state_d   = ST_FETCH;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        // A retry always restarts from the write phase, even when the readback failed.
        if (retry) begin
            if (int'(rty_q) < MAX_RETRY) begin
                rty_d   = rty_q + RTY_W'(1);
                rd_d    = 1'b0;
                cnt_d   = CNT_W'(RETRY_GAP);
                state_d = ST_GAP;
            end else begin
                err_idx_d = idx_q;
                state_d   = ST_ERR;
            end
        end

        if (next_entry) begin
            rty_d = '0;
            idx_d = idx_q + IDX_W'(1);
            if (idx_q == IDX_W'(NUM_ENTRIES - 1)) begin
                cnt_d   = CNT_W'(POST_DELAY);
                state_d = ST_POST;
            end else begin
                state_d = ST_FETCH;
            end
        end
    end

    assign rom_addr  = idx_q;
    assign txn_start = (state_q == ST_ISSUE);
    assign txn_rd    = rd_q;
    assign txn_dev   = ent_q.dev;
    assign txn_addr  = ent_q.addr;
    assign txn_wdata = ent_q.val;
    assign cfg_busy  = !(state_q inside {ST_IDLE, ST_DONE, ST_ERR});
    assign cfg_done  = (state_q == ST_DONE);
    assign cfg_err   = (state_q == ST_ERR);
    assign err_index = err_idx_q;

endmodule
